// File: rtl/riscv_ctrl_pkg.sv
// Purpose : Shared types and constants for the multicycle RISC-V main controller.
//           Holds the controller state enum, the supported opcodes, the alu_op
//           encodings sent to the ALU decoder and the datapath mux-select codes.
// Ports   : none (package).
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMREAD  = 4'd4,
        MEMWB    = 4'd5,
        MEMWRITE = 4'd6,
        EXEC_R   = 4'd7,
        EXEC_I   = 4'd8,
        ALUWB    = 4'd9,
        BEQ      = 4'd10,
        JAL      = 4'd11,
        FAULT    = 4'd12
    } state_t;

    // Opcodes (instruction bits [6:0])
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // alu_op encodings for the downstream ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU source A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU source B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Memory address select
    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

endpackage

// File: rtl/multicycle_main_fsm.sv
// Purpose : Multicycle RISC-V main controller. Walks each instruction through
//           fetch / decode / execute / memory / writeback and drives the datapath
//           mux selects, write enables and alu_op. Memory accesses use a req/ready
//           handshake guarded by a wait counter; a stall longer than WAIT_LIMIT
//           cycles, or an unknown opcode, parks the FSM in a sticky FAULT state.
// Ports   :
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   op[6:0]     in   opcode from the instruction register
//   mem_ready   in   memory completes the current access this cycle
//   mem_req     out  memory access request (fetch, load, store)
//   adr_src     out  memory address: 0 = PC, 1 = ALUOut
//   ir_write    out  load IR and OldPC
//   pc_update   out  unconditional PC write
//   branch      out  PC write qualified by Zero in the datapath
//   reg_write   out  register-file write
//   mem_write   out  store strobe
//   alu_src_a   out  00 = PC, 01 = OldPC, 10 = rs1
//   alu_src_b   out  00 = rs2, 01 = immediate, 10 = constant 4
//   result_src  out  00 = ALUOut, 01 = read data, 10 = ALU result
//   alu_op      out  00 = ADD, 01 = SUB, 10 = decode by funct fields
//   fault       out  sticky fault indication
//   instr_done  out  pulse on the last cycle of each instruction
module multicycle_main_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_update,
    output logic       branch,
    output logic       reg_write,
    output logic       mem_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       fault,
    output logic       instr_done
);

    state_t           r_state;
    state_t           w_state_d;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_d;
    logic             w_timeout;

    // The counter holds the number of stalled cycles already seen in this state;
    // once it equals WAIT_LIMIT the current cycle is the first one past the limit.
    assign w_timeout = (r_wait_cnt == CNT_W'(WAIT_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_wait_cnt <= w_wait_cnt_d;
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        adr_src      = ADR_PC;
        ir_write     = 1'b0;
        pc_update    = 1'b0;
        branch       = 1'b0;
        reg_write    = 1'b0;
        mem_write    = 1'b0;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RS2;
        result_src   = RES_ALUOUT;
        alu_op       = ALUOP_ADD;
        fault        = 1'b0;
        instr_done   = 1'b0;
        w_state_d    = r_state;
        w_wait_cnt_d = r_wait_cnt;

        unique case (r_state)
            IDLE: begin
                w_state_d = FETCH;
            end
            FETCH: begin
                mem_req    = 1'b1;
                adr_src    = ADR_PC;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                // IR load and PC+4 happen only in the cycle the fetch completes
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                if (mem_ready) begin
                    w_state_d = DECODE;
                end else if (w_timeout) begin
                    w_state_d = FAULT;
                end
            end
            DECODE: begin
                // Branch target OldPC + imm is parked in ALUOut here
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: w_state_d = MEMADR;
                    OP_R:         w_state_d = EXEC_R;
                    OP_I:         w_state_d = EXEC_I;
                    OP_BEQ:       w_state_d = BEQ;
                    OP_JAL:       w_state_d = JAL;
                    default:      w_state_d = FAULT;
                endcase
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                w_state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = ADR_ALUOUT;
                if (mem_ready) begin
                    w_state_d = MEMWB;
                end else if (w_timeout) begin
                    w_state_d = FAULT;
                end
            end
            MEMWB: begin
                result_src = RES_RDATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_state_d  = FETCH;
            end
            MEMWRITE: begin
                mem_req    = 1'b1;
                adr_src    = ADR_ALUOUT;
                mem_write  = mem_ready;
                instr_done = mem_ready;
                if (mem_ready) begin
                    w_state_d = FETCH;
                end else if (w_timeout) begin
                    w_state_d = FAULT;
                end
            end
            EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
                w_state_d = ALUWB;
            end
            EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                w_state_d = ALUWB;
            end
            ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_state_d  = FETCH;
            end
            BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                branch     = 1'b1;
                instr_done = 1'b1;
                w_state_d  = FETCH;
            end
            JAL: begin
                // Jump target from DECODE goes to PC; ALU computes OldPC+4 for rd
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_update  = 1'b1;
                w_state_d  = ALUWB;
            end
            FAULT: begin
                fault     = 1'b1;
                w_state_d = FAULT;
            end
            default: begin
                w_state_d = FAULT;
            end
        endcase

        if (w_state_d != r_state) begin
            w_wait_cnt_d = '0;
        end else if (mem_req && !mem_ready && !w_timeout) begin
            w_wait_cnt_d = r_wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
module tb_multicycle_main_fsm;

    localparam int unsigned WAIT_LIMIT = 16;
    localparam int unsigned CNT_W      = 5;

    // Output vector layout:
    // [16]mem_req [15]adr_src [14]ir_write [13]pc_update [12]branch [11]reg_write
    // [10]mem_write [9:8]alu_src_a [7:6]alu_src_b [5:4]result_src [3:2]alu_op
    // [1]fault [0]instr_done
    localparam logic [16:0] V_IDLE   = 17'b0_0_0_0_0_0_0_00_00_00_00_0_0;
    localparam logic [16:0] V_FETCH0 = 17'b1_0_0_0_0_0_0_00_10_10_00_0_0;
    localparam logic [16:0] V_FETCH1 = 17'b1_0_1_1_0_0_0_00_10_10_00_0_0;
    localparam logic [16:0] V_DECODE = 17'b0_0_0_0_0_0_0_01_01_00_00_0_0;
    localparam logic [16:0] V_MEMADR = 17'b0_0_0_0_0_0_0_10_01_00_00_0_0;
    localparam logic [16:0] V_MEMRD  = 17'b1_1_0_0_0_0_0_00_00_00_00_0_0;
    localparam logic [16:0] V_MEMWB  = 17'b0_0_0_0_0_1_0_00_00_01_00_0_1;
    localparam logic [16:0] V_MEMWR0 = 17'b1_1_0_0_0_0_0_00_00_00_00_0_0;
    localparam logic [16:0] V_MEMWR1 = 17'b1_1_0_0_0_0_1_00_00_00_00_0_1;
    localparam logic [16:0] V_EXECR  = 17'b0_0_0_0_0_0_0_10_00_00_10_0_0;
    localparam logic [16:0] V_EXECI  = 17'b0_0_0_0_0_0_0_10_01_00_10_0_0;
    localparam logic [16:0] V_ALUWB  = 17'b0_0_0_0_0_1_0_00_00_00_00_0_1;
    localparam logic [16:0] V_BEQ    = 17'b0_0_0_0_1_0_0_10_00_00_01_0_1;
    localparam logic [16:0] V_JAL    = 17'b0_0_0_1_0_0_0_01_10_00_00_0_0;
    localparam logic [16:0] V_FAULT  = 17'b0_0_0_0_0_0_0_00_00_00_00_1_0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       mem_ready;
    logic       mem_req, adr_src, ir_write, pc_update, branch, reg_write, mem_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic       fault, instr_done;
    logic [16:0] obs;

    int checks = 0;
    int errors = 0;

    multicycle_main_fsm #(
        .WAIT_LIMIT(WAIT_LIMIT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .adr_src   (adr_src),
        .ir_write  (ir_write),
        .pc_update (pc_update),
        .branch    (branch),
        .reg_write (reg_write),
        .mem_write (mem_write),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .result_src(result_src),
        .alu_op    (alu_op),
        .fault     (fault),
        .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, adr_src, ir_write, pc_update, branch, reg_write, mem_write,
                  alu_src_a, alu_src_b, result_src, alu_op, fault, instr_done};

    // Leaves the bench 1 time unit into the first FETCH cycle after reset.
    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        op        = 7'b0110011;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== V_IDLE) begin
            $display("FAIL reset_state: got %b expected %b", obs, V_IDLE);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== V_IDLE) begin
            $display("FAIL idle_after_release: got %b expected %b", obs, V_IDLE);
            errors++;
        end
        @(posedge clk);
        #1;
    endtask

    // Continues from test_reset: already in FETCH with mem_ready=1.
    task automatic test_rtype();
        logic [16:0] ev [5];
        ev = '{V_FETCH1, V_DECODE, V_EXECR, V_ALUWB, V_FETCH1};
        op = 7'b0110011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1;
            #1;
            checks++;
            if (obs !== ev[i]) begin
                $display("FAIL rtype step %0d: got %b expected %b", i, obs, ev[i]);
                errors++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_itype();
        logic [16:0] ev [5];
        logic        rv [5];
        ev = '{V_FETCH1, V_DECODE, V_EXECI, V_ALUWB, V_FETCH0};
        rv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        op = 7'b0010011;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mem_ready = rv[i];
            #1;
            checks++;
            if (obs !== ev[i]) begin
                $display("FAIL itype step %0d: got %b expected %b", i, obs, ev[i]);
                errors++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_lw();
        logic [16:0] ev [9];
        logic        rv [9];
        int          req_cycles;
        ev = '{V_FETCH1, V_DECODE, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB,
               V_FETCH0};
        rv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        op = 7'b0000011;
        req_cycles = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            mem_ready = rv[i];
            #1;
            if (i >= 3 && i <= 7 && mem_req) req_cycles++;
            checks++;
            if (obs !== ev[i]) begin
                $display("FAIL lw step %0d: got %b expected %b", i, obs, ev[i]);
                errors++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (req_cycles !== 4) begin
            $display("FAIL lw_req_cycles: got %0d expected 4", req_cycles);
            errors++;
        end
    endtask

    task automatic test_sw();
        logic [16:0] ev [7];
        logic        rv [7];
        int          rw_seen;
        ev = '{V_FETCH1, V_DECODE, V_MEMADR, V_MEMWR0, V_MEMWR0, V_MEMWR1, V_FETCH0};
        rv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        op = 7'b0100011;
        rw_seen = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            mem_ready = rv[i];
            #1;
            if (reg_write) rw_seen++;
            checks++;
            if (obs !== ev[i]) begin
                $display("FAIL sw step %0d: got %b expected %b", i, obs, ev[i]);
                errors++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (rw_seen !== 0) begin
            $display("FAIL sw_no_reg_write: got %0d expected 0", rw_seen);
            errors++;
        end
    endtask

    task automatic test_beq();
        logic [16:0] ev [4];
        logic        rv [4];
        ev = '{V_FETCH1, V_DECODE, V_BEQ, V_FETCH0};
        rv = '{1'b1, 1'b0, 1'b0, 1'b0};
        op = 7'b1100011;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mem_ready = rv[i];
            #1;
            checks++;
            if (obs !== ev[i]) begin
                $display("FAIL beq step %0d: got %b expected %b", i, obs, ev[i]);
                errors++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_jal();
        logic [16:0] ev [5];
        logic        rv [5];
        ev = '{V_FETCH1, V_DECODE, V_JAL, V_ALUWB, V_FETCH0};
        rv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        op = 7'b1101111;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mem_ready = rv[i];
            #1;
            checks++;
            if (obs !== ev[i]) begin
                $display("FAIL jal step %0d: got %b expected %b", i, obs, ev[i]);
                errors++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_illegal();
        int bad;
        op = 7'b1111111;
        do_reset();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== V_FETCH1) begin
            $display("FAIL illegal_fetch: got %b expected %b", obs, V_FETCH1);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== V_DECODE) begin
            $display("FAIL illegal_decode: got %b expected %b", obs, V_DECODE);
            errors++;
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            mem_ready = i[0];
            op        = 7'b0110011;
            #1;
            if (obs !== V_FAULT) bad++;
        end
        checks++;
        if (bad !== 0) begin
            $display("FAIL illegal_fault_hold: got %0d bad cycles expected 0 (last %b)", bad, obs);
            errors++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== V_IDLE) begin
            $display("FAIL fault_reset_exit: got %b expected %b", obs, V_IDLE);
            errors++;
        end
    endtask

    task automatic test_reset_mid_access();
        op = 7'b0110011;
        do_reset();
        mem_ready = 1'b0;
        #1;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            $display("FAIL mid_reset_req_drop: got %b expected 0", mem_req);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // mem_ready seen during reset must not have completed anything
        checks++;
        if (obs !== V_FETCH1) begin
            $display("FAIL mid_reset_restart: got %b expected %b", obs, V_FETCH1);
            errors++;
        end
    endtask

    task automatic test_fetch_timeout();
        int bad;
        op = 7'b0110011;
        do_reset();
        bad = 0;
        for (int i = 0; i <= WAIT_LIMIT; i++) begin
            mem_ready = 1'b0;
            #1;
            if (obs !== V_FETCH0) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad !== 0) begin
            $display("FAIL timeout_stall: got %0d bad cycles expected 0", bad);
            errors++;
        end
        checks++;
        if (obs !== V_FAULT) begin
            $display("FAIL timeout_fault: got %b expected %b", obs, V_FAULT);
            errors++;
        end

        do_reset();
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            mem_ready = 1'b0;
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== V_FETCH1) begin
            $display("FAIL timeout_limit_ready: got %b expected %b", obs, V_FETCH1);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== V_DECODE) begin
            $display("FAIL timeout_limit_decode: got %b expected %b", obs, V_DECODE);
            errors++;
        end
    endtask

    task automatic test_memread_timeout();
        op = 7'b0000011;
        do_reset();
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_ready = 1'b0;
        repeat (WAIT_LIMIT + 1) @(posedge clk);
        #1;
        checks++;
        if (obs !== V_FAULT) begin
            $display("FAIL memread_timeout: got %b expected %b", obs, V_FAULT);
            errors++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        op        = 7'b0;
        mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_itype();
        test_lw();
        test_sw();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_mid_access();
        test_fetch_timeout();
        test_memread_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
